pov_frame_writer: RTL
=====================

Name: pov_frame_writer

Overview:
- Write side of the POV column interface. Accepts a stream of 16-bit LED column words and assembles them into a ping-pong frame buffer.
- The LED driver (top_leds side) reads columns by address.
- A completed frame becomes visible only at the reader's next frame_start pulse, so the display never shows a partially written image.
- Sits between the pattern/string loader and the LED column scanner.

Parameters:
- COLS, 64, columns per frame (power of two, ≥ 4).
- LED_W, 16, bits per column (one bit per LED).
- ADDR_W, 6, column address width; must equal log2(COLS). Shared constant, not overridden independently.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  column word offered.
- in_ready  out  1  writer can accept a column this cycle.
- in_data  in  LED_W  column pattern; bit i drives LED i.
- in_last  in  1  marks the final column of a frame; qualified by in_valid.
- frame_start  in  1  one-cycle pulse from the reader at the start of a display revolution (column 0).
- rd_addr  in  ADDR_W  column address from the reader.
- rd_data  out  LED_W  column pattern for rd_addr; 1-cycle latency.
- frame_valid  out  1  at least one frame has been swapped to display.
- frame_pending  out  1  a completed frame is waiting for frame_start.
- trunc_err  out  1  sticky: a frame exceeded COLS columns without in_last.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=ACCEPT, wptr=0, disp_bank=0 (write bank = 1).
  - in_ready=0 during reset, 1 from the first cycle after release.
  - frame_valid=0, frame_pending=0, trunc_err=0, rd_data=0.
  - RAM contents are not cleared.
  - Reset mid-frame discards the partial frame; the displayed bank reverts to bank 0.
- Transfer: occurs when in_valid && in_ready. The word is written to wbank[wptr], then wptr increments.
- States:
  - ACCEPT: in_ready=1. A transfer with in_last=1 and wptr<COLS-1 → PAD. A transfer at wptr=COLS-1 (any in_last) → PENDING.
  - ACCEPT, overlong frame: a transfer at wptr=COLS-1 with in_last=0 sets trunc_err (sticky until reset). Words after that point belong to the next frame.
  - PAD: in_ready=0. Writes 0 to wbank[wptr] one column per cycle. After writing COLS-1 → PENDING. A frame of N columns takes COLS-N pad cycles.
  - PENDING: in_ready=0, frame_pending=1. On frame_start: disp_bank toggles, frame_valid=1, wptr=0 → ACCEPT. in_ready=1 on the next cycle.
- frame_start in ACCEPT or PAD is ignored; the old frame keeps displaying.
- Read path: rd_data is a registered read of disp_bank[rd_addr].
  - Reads sampled in the frame_start cycle return the old bank.
  - Reads sampled from the next cycle onward return the new bank.
  - rd_data=0 while frame_valid=0.
- Write and read never target the same bank, so no read/write collision.
- wptr wraps via the state transitions only and is never left at COLS.
- Simultaneous in_last transfer at wptr=COLS-1 → PENDING directly, no PAD, trunc_err unchanged.

Decomposition:
- Shared package pov_pkg holds:
  - COLS, LED_W, ADDR_W constants.
  - State encoding (ACCEPT, PAD, PENDING).
- Sub-module pov_col_ram: dual-port RAM of 2·COLS×LED_W.
  - Write port: address {bank, addr}.
  - Registered read port.
  - Inferable as block RAM.
- The FSM and bank control stay in pov_frame_writer.

Test Plan:
- Reset → in_ready=0 during rst_n=0, then 1. frame_valid=0, rd_data=0 for any rd_addr.
- Full frame: 64 words 16'h0001<<(i%16), in_last on word 63 → frame_pending=1, in_ready=0. frame_start pulse → next-cycle reads: addr 5 gives 16'h0020 one cycle later, frame_valid=1, in_ready=1.
- Short frame: 3 words A5A5, 5A5A, FFFF with in_last on the third → 61 PAD cycles, then pending. After swap: addr 0..2 give the words, addr 3..63 give 0000.
- Swap timing: during display of frame A, complete frame B. Read addr 10 in the frame_start cycle → A's value. Read in the following cycle → B's value.
- Overlong: 65 words, no in_last → trunc_err=1 after word 64 (index 63). Word 65 is accepted into the next frame at wptr 0 after the swap.
- Reset mid-frame: rst_n low after 20 words → frame_pending=0, frame_valid=0, wptr restarts. A new 64-word frame displays correctly.

Source files
------------

// File: rtl/pov_pkg.sv
// Shared constants and state encoding for the POV frame writer.
// Column geometry is fixed here so every block agrees on it.
package pov_pkg;

    localparam int COLS   = 64;
    localparam int LED_W  = 16;
    localparam int ADDR_W = $clog2(COLS);
    localparam int RAM_AW = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_ACCEPT  = 2'd0,
        ST_PAD     = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

endpackage

// File: rtl/pov_col_ram.sv
// Ping-pong column store: two banks of COLS words, address {bank, col}.
// Registered read; output forced to zero when no readable frame exists.
module pov_col_ram
    import pov_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [RAM_AW-1:0] i_waddr,
    input  logic [LED_W-1:0]  i_wdata,
    input  logic              i_rd_en,
    input  logic [RAM_AW-1:0] i_raddr,
    output logic [LED_W-1:0]  o_rdata
);

    logic [LED_W-1:0] r_mem [2*COLS];
    logic [LED_W-1:0] r_rdata;

    // Write port into the bank the writer owns
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; disabled read returns blank column
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pov_frame_writer.sv
// Assembles incoming column words into the write bank and swaps banks
// only at the reader's frame_start, so no partial image is ever shown.
module pov_frame_writer
    import pov_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [LED_W-1:0]  i_in_data,
    input  logic              i_in_last,
    input  logic              i_frame_start,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [LED_W-1:0]  o_rd_data,
    output logic              o_frame_valid,
    output logic              o_frame_pending,
    output logic              o_trunc_err
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] w_wptr_nxt;
    logic              r_disp_bank;
    logic              w_disp_bank_nxt;
    logic              r_frame_valid;
    logic              w_frame_valid_nxt;
    logic              r_trunc_err;
    logic              w_trunc_err_nxt;
    logic              w_we;
    logic [LED_W-1:0]  w_wdata;
    logic              w_xfer;
    logic              w_at_last;

    assign o_in_ready      = i_rst_n && (r_state == ST_ACCEPT);
    assign w_xfer          = i_in_valid && o_in_ready;
    assign w_at_last       = (r_wptr == LAST_COL);
    assign o_frame_valid   = r_frame_valid;
    assign o_frame_pending = (r_state == ST_PENDING);
    assign o_trunc_err     = r_trunc_err;

    // Next-state: accept words, zero-pad short frames, wait for swap
    always_comb begin
        w_state_nxt       = r_state;
        w_wptr_nxt        = r_wptr;
        w_disp_bank_nxt   = r_disp_bank;
        w_frame_valid_nxt = r_frame_valid;
        w_trunc_err_nxt   = r_trunc_err;
        w_we              = 1'b0;
        w_wdata           = i_in_data;
        unique case (r_state)
            ST_ACCEPT: begin
                if (w_xfer) begin
                    w_we = 1'b1;
                    if (w_at_last) begin
                        w_state_nxt = ST_PENDING;
                        w_wptr_nxt  = '0;
                        if (!i_in_last) begin
                            w_trunc_err_nxt = 1'b1;
                        end
                    end else begin
                        w_wptr_nxt = r_wptr + 1'b1;
                        if (i_in_last) begin
                            w_state_nxt = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                w_we    = 1'b1;
                w_wdata = '0;
                if (w_at_last) begin
                    w_state_nxt = ST_PENDING;
                    w_wptr_nxt  = '0;
                end else begin
                    w_wptr_nxt = r_wptr + 1'b1;
                end
            end
            ST_PENDING: begin
                if (i_frame_start) begin
                    w_state_nxt       = ST_ACCEPT;
                    w_wptr_nxt        = '0;
                    w_disp_bank_nxt   = ~r_disp_bank;
                    w_frame_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ACCEPT;
                w_wptr_nxt  = '0;
            end
        endcase
    end

    // State, pointer and bank registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_ACCEPT;
            r_wptr        <= '0;
            r_disp_bank   <= 1'b0;
            r_frame_valid <= 1'b0;
            r_trunc_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wptr        <= w_wptr_nxt;
            r_disp_bank   <= w_disp_bank_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_trunc_err   <= w_trunc_err_nxt;
        end
    end

    pov_col_ram u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we && i_rst_n),
        .i_waddr ({~r_disp_bank, r_wptr}),
        .i_wdata (w_wdata),
        .i_rd_en (i_rst_n && r_frame_valid),
        .i_raddr ({r_disp_bank, i_rd_addr}),
        .o_rdata (o_rd_data)
    );

endmodule
